// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, config-pair type and helpers for the
// programmable clock divider (clk_div_prog / clk_div_core).

package clk_div_pkg;

    // Field width of the divisor / high-phase pair carried in clk_div_cfg_t.
    // The divider's CNT_W parameter defaults to this value and must match it.
    localparam int CLK_DIV_CNT_W = 16;

    // Smallest divisor that still produces a high and a low phase.
    localparam int DIV_MIN = 2;

    // Divisor D and high-phase length H, always handled as a pair.
    typedef struct packed {
        logic [CLK_DIV_CNT_W-1:0] div;
        logic [CLK_DIV_CNT_W-1:0] hi;
    } clk_div_cfg_t;

    // ceil(D/2): 50% duty for even D, one extra high cycle for odd D.
    // Cannot overflow: the result is at most half the field range plus one.
    function automatic logic [CLK_DIV_CNT_W-1:0] default_hi(
        input logic [CLK_DIV_CNT_W-1:0] d
    );
        return (d >> 1) + {{(CLK_DIV_CNT_W-1){1'b0}}, d[0]};
    endfunction

    // Load validity: D >= DIV_MIN, and when chk_hi is set also 1 <= H <= D-1.
    function automatic logic cfg_ok(
        input clk_div_cfg_t c,
        input logic         chk_hi
    );
        logic ok;
        ok = (c.div >= CLK_DIV_CNT_W'(DIV_MIN));
        if (chk_hi) begin
            ok = ok && (c.hi != {CLK_DIV_CNT_W{1'b0}}) && (c.hi < c.div);
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter and output generation for clk_div_prog.
// Given the active divisor and the high-phase length that will be active
// after the current edge, it runs the counter and produces registered
// clk_out / tick. It also reports when the current edge is a period wrap so
// the top level can swap in a pending configuration exactly there.

module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CLK_DIV_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,      // divisor of the period in progress
    input  logic [CNT_W-1:0] i_hi_nxt,   // high length in force after this edge
    output logic             o_running,
    output logic             o_wrap,     // this edge ends the current period
    output logic             o_clk_out,
    output logic             o_tick
);

    logic             r_running;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Detect the last cycle of the period; >= keeps the counter bounded even
    // if it were ever found beyond D-1.
    always_comb begin
        w_wrap = r_running && (r_cnt >= (i_div - {{(CNT_W-1){1'b0}}, 1'b1}));
    end

    // Next counter value while running: increment, wrapping D-1 -> 0.
    always_comb begin
        if (w_wrap) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Run/stop control, counter, and registered outputs derived from the
    // counter value that will hold after this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_running <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!i_en) begin
            // Stop truncates the period at once and parks the output low.
            r_running <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (!r_running) begin
            // First edge with en high starts a fresh period, high phase first.
            r_running <= 1'b1;
            r_cnt     <= {CNT_W{1'b0}};
            r_clk_out <= 1'b1;
            r_tick    <= 1'b1;
        end else begin
            r_running <= 1'b1;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= (w_cnt_nxt < i_hi_nxt);
            r_tick    <= (w_cnt_nxt == {CNT_W{1'b0}});
        end
    end

    assign o_running = r_running;
    assign o_wrap    = w_wrap;
    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
// Produces a registered divided clock and a one-cycle tick at the start of
// each period for any divisor 2..2^CNT_W-1. A new divisor (and, with
// CLK_DIV_DUTY_EN defined, a new high-phase length) is loaded through a
// valid/ready handshake; while running it waits in a pending register and
// takes effect only at a period boundary so no runt or stretched pulse
// appears. Optional feature macro: CLK_DIV_DUTY_EN (programmable duty).

module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int          CNT_W    = CLK_DIV_CNT_W,
    parameter int unsigned DIV_INIT = 32'd4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div_in,
    input  logic [CNT_W-1:0] i_hi_in,
    input  logic             i_div_wr,
    output logic             o_div_rdy,
    output logic             o_div_err,
    output logic [CNT_W-1:0] o_cur_div,
    output logic             o_clk_out,
    output logic             o_tick
);

    localparam clk_div_cfg_t CFG_RST = '{
        div: CNT_W'(DIV_INIT),
        hi:  default_hi(CNT_W'(DIV_INIT))
    };
    localparam clk_div_cfg_t CFG_ZERO = '{
        div: {CNT_W{1'b0}},
        hi:  {CNT_W{1'b0}}
    };

    clk_div_cfg_t r_act_cfg;      // configuration in force
    clk_div_cfg_t r_pend_cfg;     // accepted while running, not yet applied
    logic         r_pend_vld;
    logic         r_div_rdy;
    logic         r_div_err;

    clk_div_cfg_t w_req_cfg;
    logic         w_req_ok;
    logic         w_accept;
    clk_div_cfg_t w_nxt_cfg;
    clk_div_cfg_t w_nxt_pend_cfg;
    logic         w_nxt_pend_vld;
    logic         w_running;
    logic         w_wrap;

`ifdef CLK_DIV_DUTY_EN
    // Requested pair taken as given; H must lie in 1..D-1.
    always_comb begin
        w_req_cfg = '{div: i_div_in, hi: i_hi_in};
        w_req_ok  = cfg_ok(w_req_cfg, 1'b1);
    end
`else
    logic [CNT_W-1:0] w_unused_hi;

    // Fixed duty: H derived from D, so hi_in plays no part.
    always_comb begin
        w_req_cfg = '{div: i_div_in, hi: default_hi(i_div_in)};
        w_req_ok  = cfg_ok(w_req_cfg, 1'b0);
    end

    assign w_unused_hi = i_hi_in;
`endif

    assign w_accept = i_div_wr && r_div_rdy && w_req_ok;

    // Decide which configuration is in force after this edge and what stays
    // pending: direct load while idle, swap at wrap or stop while running.
    always_comb begin
        w_nxt_cfg      = r_act_cfg;
        w_nxt_pend_cfg = r_pend_cfg;
        w_nxt_pend_vld = r_pend_vld;
        if (!w_running) begin
            if (w_accept) begin
                w_nxt_cfg = w_req_cfg;
            end else begin
                w_nxt_cfg = r_act_cfg;
            end
        end else if (!i_en) begin
            // Stopping ends the period, so any pending load lands now.
            w_nxt_pend_vld = 1'b0;
            if (r_pend_vld) begin
                w_nxt_cfg = r_pend_cfg;
            end else if (w_accept) begin
                w_nxt_cfg = w_req_cfg;
            end else begin
                w_nxt_cfg = r_act_cfg;
            end
        end else if (w_wrap && r_pend_vld) begin
            w_nxt_cfg      = r_pend_cfg;
            w_nxt_pend_vld = 1'b0;
        end else if (w_accept) begin
            w_nxt_pend_cfg = w_req_cfg;
            w_nxt_pend_vld = 1'b1;
        end else begin
            w_nxt_pend_vld = r_pend_vld;
        end
    end

    // Configuration, pending slot and handshake registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act_cfg  <= CFG_RST;
            r_pend_cfg <= CFG_ZERO;
            r_pend_vld <= 1'b0;
            r_div_rdy  <= 1'b1;
            r_div_err  <= 1'b0;
        end else begin
            r_act_cfg  <= w_nxt_cfg;
            r_pend_cfg <= w_nxt_pend_cfg;
            r_pend_vld <= w_nxt_pend_vld;
            // Ready only while the pending slot is free.
            r_div_rdy  <= !w_nxt_pend_vld;
            r_div_err  <= i_div_wr && !w_req_ok;
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_div     (r_act_cfg.div),
        .i_hi_nxt  (w_nxt_cfg.hi),
        .o_running (w_running),
        .o_wrap    (w_wrap),
        .o_clk_out (o_clk_out),
        .o_tick    (o_tick)
    );

    assign o_div_rdy = r_div_rdy;
    assign o_div_err = r_div_err;
    assign o_cur_div = r_act_cfg.div;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: self-checking bench for clk_div_prog. A behavioural
// model tracks the position inside the current period plus the active and
// pending (D, H) pairs; expected outputs follow from that position.

module tb_clk_div_prog;

    localparam int DIV_INIT = 4;

    logic        clk;
    logic        tb_rst;
    logic        tb_en;
    logic [15:0] tb_div;
    logic [15:0] tb_hi;
    logic        tb_wr;
    logic        o_div_rdy;
    logic        o_div_err;
    logic [15:0] o_cur_div;
    logic        o_clk_out;
    logic        o_tick;
    logic [19:0] obs;

    int n_cmp;
    int n_err;
    int cyc;

    // model state
    int m_run, m_pos, m_D, m_H, m_pv, m_pD, m_pH;
    bit m_rdy, m_err;

    clk_div_prog #(.CNT_W(16), .DIV_INIT(DIV_INIT)) dut (
        .i_clk     (clk),
        .i_rst     (tb_rst),
        .i_en      (tb_en),
        .i_div_in  (tb_div),
        .i_hi_in   (tb_hi),
        .i_div_wr  (tb_wr),
        .o_div_rdy (o_div_rdy),
        .o_div_err (o_div_err),
        .o_cur_div (o_cur_div),
        .o_clk_out (o_clk_out),
        .o_tick    (o_tick)
    );

    assign obs = {o_clk_out, o_tick, o_div_rdy, o_div_err, o_cur_div};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_D = DIV_INIT; m_H = (DIV_INIT + 1) / 2;
        m_pv = 0; m_pD = 0; m_pH = 0; m_rdy = 1'b1; m_err = 1'b0;
    endtask

    // Applies the rules for one rising edge using the inputs driven then.
    task automatic model_edge();
        int d, h, hh;
        bit valid, acc;
        d = int'(tb_div);
        h = int'(tb_hi);
        if (tb_rst) begin
            model_reset();
            return;
        end
`ifdef CLK_DIV_DUTY_EN
        valid = (d >= 2) && (h >= 1) && (h < d);
        hh = h;
`else
        valid = (d >= 2);
        hh = (d + 1) / 2;
`endif
        acc = tb_wr && m_rdy && valid;
        m_err = tb_wr && !valid;
        if (m_run == 0) begin
            if (acc) begin m_D = d; m_H = hh; end
            if (tb_en) begin m_run = 1; m_pos = 0; end
        end else if (!tb_en) begin
            if (m_pv != 0) begin m_D = m_pD; m_H = m_pH; m_pv = 0; end
            else if (acc) begin m_D = d; m_H = hh; end
            m_run = 0; m_pos = 0;
        end else begin
            if (m_pos == m_D - 1) begin
                m_pos = 0;
                if (m_pv != 0) begin m_D = m_pD; m_H = m_pH; m_pv = 0; end
            end else begin
                m_pos = m_pos + 1;
            end
            if (acc) begin m_pD = d; m_pH = hh; m_pv = 1; end
        end
        m_rdy = (m_pv == 0);
    endtask

    function automatic logic [19:0] model_vec();
        logic c, t;
        c = (m_run != 0) && (m_pos < m_H);
        t = (m_run != 0) && (m_pos == 0);
        return {c, t, m_rdy, m_err, 16'(m_D)};
    endfunction

    // Drives inputs, lets one rising edge pass, advances the model, then
    // waits 1 time unit so outputs are sampled well away from the edge.
    task automatic step(input bit rst, input bit en, input bit wr, input int d, input int h);
        tb_rst = rst; tb_en = en; tb_wr = wr; tb_div = 16'(d); tb_hi = 16'(h);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 16'd4}) begin
            n_err++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs, {1'b0, 1'b0, 1'b1, 1'b0, 16'd4});
        end
        step(1'b0, 1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (obs !== model_vec()) begin
            n_err++; $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", cyc, obs, model_vec());
        end
    endtask

    task automatic test_default_run();
        logic [11:0] pat, tk;
        pat = 12'd0; tk = 12'd0;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++; $display("FAIL default_run_model cyc=%0d got=%h exp=%h", cyc, obs, model_vec());
            end
            pat = {pat[10:0], o_clk_out};
            tk  = {tk[10:0], o_tick};
        end
        n_cmp++;
        if (pat !== 12'b110011001100) begin
            n_err++; $display("FAIL default_pattern got=%b exp=%b", pat, 12'b110011001100);
        end
        n_cmp++;
        if (tk !== 12'b100010001000) begin
            n_err++; $display("FAIL default_tick got=%b exp=%b", tk, 12'b100010001000);
        end
        n_cmp++;
        if (o_cur_div !== 16'd4) begin
            n_err++; $display("FAIL default_cur_div got=%0d exp=4", o_cur_div);
        end
    endtask

    task automatic test_idle_load();
        logic [9:0] pat, tk;
        pat = 10'd0; tk = 10'd0;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 5, 3);
        n_cmp++;
        if (o_cur_div !== 16'd5 || o_div_rdy !== 1'b1 || o_clk_out !== 1'b0) begin
            n_err++; $display("FAIL idle_load_apply got cur=%0d rdy=%b clk=%b exp cur=5 rdy=1 clk=0", o_cur_div, o_div_rdy, o_clk_out);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++; $display("FAIL idle_load_model cyc=%0d got=%h exp=%h", cyc, obs, model_vec());
            end
            pat = {pat[8:0], o_clk_out};
            tk  = {tk[8:0], o_tick};
        end
        n_cmp++;
        if (pat !== 10'b1110011100 || tk !== 10'b1000010000) begin
            n_err++; $display("FAIL idle_load_pattern got=%b/%b exp=1110011100/1000010000", pat, tk);
        end
    endtask

    task automatic test_midrun_load();
        logic [8:0] pat, tk, rdy;
        pat = 9'd0; tk = 9'd0; rdy = 9'd0;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 6, 3);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 3, 2);
        n_cmp++;
        if (o_div_rdy !== 1'b0 || o_cur_div !== 16'd6) begin
            n_err++; $display("FAIL midrun_pending got rdy=%b cur=%0d exp rdy=0 cur=6", o_div_rdy, o_cur_div);
        end
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++; $display("FAIL midrun_model cyc=%0d got=%h exp=%h", cyc, obs, model_vec());
            end
            pat = {pat[7:0], o_clk_out};
            tk  = {tk[7:0], o_tick};
            rdy = {rdy[7:0], o_div_rdy};
        end
        n_cmp++;
        if (pat !== 9'b000110110 || tk !== 9'b000100100 || rdy !== 9'b000111111) begin
            n_err++; $display("FAIL midrun_pattern got clk=%b tick=%b rdy=%b exp 000110110/000100100/000111111", pat, tk, rdy);
        end
        n_cmp++;
        if (o_cur_div !== 16'd3) begin
            n_err++; $display("FAIL midrun_cur_div got=%0d exp=3", o_cur_div);
        end
    endtask

    task automatic test_invalid();
        int bad_d[4];
        int bad_h[4];
        int nbad;
        bad_d = '{1, 0, 8, 8};
        bad_h = '{1, 0, 0, 8};
`ifdef CLK_DIV_DUTY_EN
        nbad = 4;
`else
        nbad = 2;
`endif
        step(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < nbad; k++) begin
            step(1'b0, 1'b1, 1'b1, bad_d[k], bad_h[k]);
            n_cmp++;
            if (o_div_err !== 1'b1 || o_cur_div !== 16'd4 || o_div_rdy !== 1'b1) begin
                n_err++; $display("FAIL invalid_reject_%0d got err=%b cur=%0d rdy=%b exp 1/4/1", k, o_div_err, o_cur_div, o_div_rdy);
            end
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++; $display("FAIL invalid_model_%0d cyc=%0d got=%h exp=%h", k, cyc, obs, model_vec());
            end
            step(1'b0, 1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (o_div_err !== 1'b0 || obs !== model_vec()) begin
                n_err++; $display("FAIL invalid_pulse_end_%0d got=%h exp=%h", k, obs, model_vec());
            end
        end
    endtask

`ifdef CLK_DIV_DUTY_EN
    task automatic test_duty();
        logic [9:0] pat;
        pat = 10'd0;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 10, 3);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            pat = {pat[8:0], o_clk_out};
        end
        n_cmp++;
        if (pat !== 10'b1110000000) begin
            n_err++; $display("FAIL duty_pattern got=%b exp=1110000000", pat);
        end
    endtask
`endif

    task automatic test_rst_pending();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 6, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 3, 2);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 16'd4}) begin
            n_err++; $display("FAIL rst_pending got=%h exp=%h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 16'd4});
        end
        // Discarded load must not surface: period back to the default of 4.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0);
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++; $display("FAIL rst_pending_after cyc=%0d got=%h exp=%h", cyc, obs, model_vec());
            end
        end
    endtask

    task automatic test_random();
        bit en;
        en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            int d, h;
            bit wr, rs;
            if ($urandom_range(0, 19) == 0) en = ~en;
            wr = ($urandom_range(0, 6) == 0);
            rs = ($urandom_range(0, 249) == 0);
            d  = int'($urandom_range(0, 12));
            h  = int'($urandom_range(0, 13));
            step(rs, en, wr, d, h);
            n_cmp++;
            if (obs !== model_vec()) begin
                n_err++; $display("FAIL random cyc=%0d d=%0d h=%0d got=%h exp=%h", cyc, d, h, obs, model_vec());
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        tb_rst = 1'b1; tb_en = 1'b0; tb_wr = 1'b0; tb_div = 16'd0; tb_hi = 16'd0;
        model_reset();
        #2;
        test_reset();
        test_default_run();
        test_idle_load();
        test_midrun_load();
        test_invalid();
`ifdef CLK_DIV_DUTY_EN
        test_duty();
`endif
        test_rst_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
